// File: rtl/ptp_bridge_ts_dmux_buf_if.sv
// Timestamp demux bus: dual-lane ingress from HSSI plus per-channel egress.
// slave = demux side, master = HSSI source and egress consumers.
interface ptp_bridge_ts_dmux_buf_if #(
  parameter int TDATA_WIDTH = 128,
  parameter int NUM_INTF    = 9
);
  logic                            hssi2dmux_0_tvalid;
  logic [TDATA_WIDTH-1:0]          hssi2dmux_0_tdata;
  logic                            hssi2dmux_1_tvalid;
  logic [TDATA_WIDTH-1:0]          hssi2dmux_1_tdata;
  logic                            dmux2hssi_tready;
  logic [NUM_INTF-1:0]             dmux2egrpt_0_tvalid;
  logic [NUM_INTF*TDATA_WIDTH-1:0] dmux2egrpt_0_tdata;
  logic [NUM_INTF-1:0]             dmux2egrpt_1_tvalid;
  logic [NUM_INTF*TDATA_WIDTH-1:0] dmux2egrpt_1_tdata;
  logic [NUM_INTF-1:0]             egrpt2dmux_tready;

  modport master (
    output hssi2dmux_0_tvalid,
    output hssi2dmux_0_tdata,
    output hssi2dmux_1_tvalid,
    output hssi2dmux_1_tdata,
    output egrpt2dmux_tready,
    input  dmux2hssi_tready,
    input  dmux2egrpt_0_tvalid,
    input  dmux2egrpt_0_tdata,
    input  dmux2egrpt_1_tvalid,
    input  dmux2egrpt_1_tdata
  );

  modport slave (
    input  hssi2dmux_0_tvalid,
    input  hssi2dmux_0_tdata,
    input  hssi2dmux_1_tvalid,
    input  hssi2dmux_1_tdata,
    input  egrpt2dmux_tready,
    output dmux2hssi_tready,
    output dmux2egrpt_0_tvalid,
    output dmux2egrpt_0_tdata,
    output dmux2egrpt_1_tvalid,
    output dmux2egrpt_1_tdata
  );
endinterface

// File: rtl/ptp_bridge_ts_dmux_buf.sv
// Egress timestamp demux: routes dual-lane HSSI TX timestamps into
// per-channel show-ahead FIFOs keyed by the fingerprint port id.
// Ports: clk, rst (sync, active-high), bus (slave: ingress lanes,
// tready, per-channel egress lanes), stat_clr, stat_drop_cnt,
// stat_badport_cnt (saturating drop statistics).
module ptp_bridge_ts_dmux_buf #(
  parameter int TX_EGR_TS_WIDTH       = 96,
  parameter int FINGERPRINT_FLD_WIDTH = 32,
  parameter int SYS_FINGERPRINT_WIDTH = 20,
  parameter int PT_WD                 = 4,
  parameter int TDATA_WIDTH           = TX_EGR_TS_WIDTH
                                        + FINGERPRINT_FLD_WIDTH,
  parameter int NUM_INTF              = 9,
  parameter int FIFO_DEPTH            = 16,
  parameter int BACKPRESSURE          = 0,
  parameter int AFULL_MARGIN          = 2,
  parameter int CNT_WIDTH             = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  ptp_bridge_ts_dmux_buf_if.slave       bus,
  input  logic                          stat_clr,
  output logic [NUM_INTF*CNT_WIDTH-1:0] stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]          stat_badport_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = 2*TDATA_WIDTH + 1;
  localparam int PID = TX_EGR_TS_WIDTH + SYS_FINGERPRINT_WIDTH;
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN_W = (AW+1)'(AFULL_MARGIN);

  logic                   ready_q;
  logic                   accept;
  logic                   s1_vld;
  logic                   s1_l1_vld;
  logic [TDATA_WIDTH-1:0] s1_d0;
  logic [TDATA_WIDTH-1:0] s1_d1;
  logic [TDATA_WIDTH-1:0] s1_d0_mod;
  logic [PT_WD-1:0]       s1_pid;
  logic [NUM_INTF-1:0]    hit;
  logic [NUM_INTF-1:0]    afull;
  logic                   bad;
  logic [CNT_WIDTH-1:0]   bad_cnt;

  assign accept = bus.hssi2dmux_0_tvalid & ready_q;
  assign bus.dmux2hssi_tready = ready_q;

  // Stage 1: capture both lanes on a lane-0 accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_l1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_l1_vld <= bus.hssi2dmux_1_tvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_d0 <= bus.hssi2dmux_0_tdata;
      s1_d1 <= bus.hssi2dmux_1_tdata;
    end
  end

  assign s1_pid = s1_d0[PID +: PT_WD];

  always_comb begin
    s1_d0_mod = s1_d0;
    s1_d0_mod[PID +: PT_WD] = '0;
  end

  // Unmatched port id means the entry has no channel to go to.
  assign bad = s1_vld & ~|hit;

  // Ready looks at post-update occupancy, so the margin only has to
  // absorb the accept in stage 1 plus the one taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= (BACKPRESSURE == 0) ? 1'b1 : ~|afull;
  end

  for (genvar i = 0; i < NUM_INTF; i++) begin : g_ch
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          used;
    logic [AW:0]          used_nx;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 rd_en;
    logic                 drop;
    logic [EW-1:0]        head;
    logic [CNT_WIDTH-1:0] cnt;

    assign hit[i]  = s1_vld && (s1_pid == PT_WD'(i));
    assign used    = wr_ptr - rd_ptr;
    assign full    = (used == DEPTH_W);
    assign empty   = (wr_ptr == rd_ptr);
    // Full is judged before any same-cycle pop.
    assign wr_en   = hit[i] & ~full;
    assign drop    = hit[i] & full;
    assign rd_en   = ~empty & bus.egrpt2dmux_tready[i];
    assign used_nx = used + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    assign afull[i] = (DEPTH_W - used_nx) < MARGIN_W;

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {s1_l1_vld, s1_d1, s1_d0_mod};
    end

    assign head = mem[rd_ptr[AW-1:0]];

    assign bus.dmux2egrpt_0_tvalid[i] = ~empty;
    assign bus.dmux2egrpt_1_tvalid[i] = ~empty & head[EW-1];
    assign bus.dmux2egrpt_0_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] =
      head[TDATA_WIDTH-1:0];
    assign bus.dmux2egrpt_1_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] =
      head[2*TDATA_WIDTH-1:TDATA_WIDTH];

    always_ff @(posedge clk) begin
      if (rst)                      cnt <= '0;
      else if (stat_clr)            cnt <= '0;
      else if (drop && (cnt != '1)) cnt <= cnt + CNT_WIDTH'(1);
    end

    assign stat_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst)                          bad_cnt <= '0;
    else if (stat_clr)                bad_cnt <= '0;
    else if (bad && (bad_cnt != '1)) bad_cnt <= bad_cnt + CNT_WIDTH'(1);
  end

  assign stat_badport_cnt = bad_cnt;

endmodule

// File: tb/tb_ptp_bridge_ts_dmux_buf.sv
// Bench for ptp_bridge_ts_dmux_buf: u0 drop mode (4-bit counters),
// u1 backpressure mode; queue model plus directed literal checks.
module tb_ptp_bridge_ts_dmux_buf;

  typedef struct packed {
    logic         l1v;
    logic [127:0] d1;
    logic [127:0] d0;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stat_clr = 1'b0;

  always #5 clk = ~clk;

  logic         in_v0 [2];
  logic         in_v1 [2];
  logic [127:0] in_d0 [2];
  logic [127:0] in_d1 [2];
  logic [8:0]   eready [2];

  logic [8:0]    o_tv0 [2];
  logic [8:0]    o_tv1 [2];
  logic [1151:0] o_td0 [2];
  logic [1151:0] o_td1 [2];
  logic          o_rdy [2];
  logic [15:0]   o_drop [2][9];
  logic [15:0]   o_bad [2];

  logic [35:0]  drop0;
  logic [3:0]   bad0;
  logic [143:0] drop1;
  logic [15:0]  bad1;

  ptp_bridge_ts_dmux_buf_if #(.TDATA_WIDTH(128), .NUM_INTF(9)) if0 ();
  ptp_bridge_ts_dmux_buf_if #(.TDATA_WIDTH(128), .NUM_INTF(9)) if1 ();

  ptp_bridge_ts_dmux_buf #(.BACKPRESSURE(0), .CNT_WIDTH(4)) u0 (
    .clk              (clk),
    .rst              (rst),
    .bus              (if0.slave),
    .stat_clr         (stat_clr),
    .stat_drop_cnt    (drop0),
    .stat_badport_cnt (bad0)
  );

  ptp_bridge_ts_dmux_buf #(.BACKPRESSURE(1), .CNT_WIDTH(16)) u1 (
    .clk              (clk),
    .rst              (rst),
    .bus              (if1.slave),
    .stat_clr         (stat_clr),
    .stat_drop_cnt    (drop1),
    .stat_badport_cnt (bad1)
  );

  assign if0.hssi2dmux_0_tvalid = in_v0[0];
  assign if0.hssi2dmux_1_tvalid = in_v1[0];
  assign if0.hssi2dmux_0_tdata  = in_d0[0];
  assign if0.hssi2dmux_1_tdata  = in_d1[0];
  assign if0.egrpt2dmux_tready  = eready[0];
  assign if1.hssi2dmux_0_tvalid = in_v0[1];
  assign if1.hssi2dmux_1_tvalid = in_v1[1];
  assign if1.hssi2dmux_0_tdata  = in_d0[1];
  assign if1.hssi2dmux_1_tdata  = in_d1[1];
  assign if1.egrpt2dmux_tready  = eready[1];

  assign o_tv0[0] = if0.dmux2egrpt_0_tvalid;
  assign o_tv1[0] = if0.dmux2egrpt_1_tvalid;
  assign o_td0[0] = if0.dmux2egrpt_0_tdata;
  assign o_td1[0] = if0.dmux2egrpt_1_tdata;
  assign o_rdy[0] = if0.dmux2hssi_tready;
  assign o_tv0[1] = if1.dmux2egrpt_0_tvalid;
  assign o_tv1[1] = if1.dmux2egrpt_1_tvalid;
  assign o_td0[1] = if1.dmux2egrpt_0_tdata;
  assign o_td1[1] = if1.dmux2egrpt_1_tdata;
  assign o_rdy[1] = if1.dmux2hssi_tready;
  assign o_bad[0] = 16'(bad0);
  assign o_bad[1] = bad1;

  for (genvar c = 0; c < 9; c++) begin : g_drop
    assign o_drop[0][c] = 16'(drop0[c*4 +: 4]);
    assign o_drop[1][c] = drop1[c*16 +: 16];
  end

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-channel queues, one-deep capture stage, counters.
  ent_t mq [18][$];
  logic         m_s1v [2];
  logic         m_s1l1 [2];
  logic [127:0] m_s1d0 [2];
  logic [127:0] m_s1d1 [2];
  int           m_drop [18];
  int           m_bad [2];
  logic         m_rdy [2];

  function automatic int cmax(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  always @(posedge clk) begin : model
    int   pid;
    bit   fullb;
    bit   r;
    logic rdy_old;
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 9; c++) begin
          mq[d*9+c].delete();
          m_drop[d*9+c] = 0;
        end
        m_bad[d] = 0;
        m_s1v[d] = 1'b0;
        m_rdy[d] = 1'b0;
      end else begin
        rdy_old = m_rdy[d];
        pid = m_s1v[d] ? int'(m_s1d0[d][119:116]) : -1;
        fullb = (pid >= 0 && pid < 9) && (mq[d*9+pid].size() == 16);
        for (int c = 0; c < 9; c++)
          if (mq[d*9+c].size() > 0 && eready[d][c])
            void'(mq[d*9+c].pop_front());
        if (pid >= 9) begin
          if (m_bad[d] < cmax(d)) m_bad[d]++;
        end else if (pid >= 0) begin
          if (fullb) begin
            if (m_drop[d*9+pid] < cmax(d)) m_drop[d*9+pid]++;
          end else begin
            e.l1v = m_s1l1[d];
            e.d1  = m_s1d1[d];
            e.d0  = m_s1d0[d];
            e.d0[119:116] = 4'h0;
            mq[d*9+pid].push_back(e);
          end
        end
        if (stat_clr) begin
          m_bad[d] = 0;
          for (int c = 0; c < 9; c++) m_drop[d*9+c] = 0;
        end
        r = 1'b1;
        if (d == 1)
          for (int c = 0; c < 9; c++)
            if (mq[9+c].size() > 14) r = 1'b0;
        m_rdy[d] = r;
        m_s1v[d] = in_v0[d] & rdy_old;
        if (in_v0[d] & rdy_old) begin
          m_s1l1[d] = in_v1[d];
          m_s1d0[d] = in_d0[d];
          m_s1d1[d] = in_d1[d];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    ent_t e;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("cmp_tready", 128'(o_rdy[d]), 128'(m_rdy[d]));
        chk("cmp_badcnt", 128'(o_bad[d]), 128'(m_bad[d]));
        for (int c = 0; c < 9; c++) begin
          chk("cmp_dropcnt", 128'(o_drop[d][c]), 128'(m_drop[d*9+c]));
          if (mq[d*9+c].size() > 0) begin
            e = mq[d*9+c][0];
            chk("cmp_tvalid0", 128'(o_tv0[d][c]), 128'(1));
            chk("cmp_tdata0", o_td0[d][c*128 +: 128], e.d0);
            chk("cmp_tvalid1", 128'(o_tv1[d][c]), 128'(e.l1v));
            if (e.l1v) chk("cmp_tdata1", o_td1[d][c*128 +: 128], e.d1);
          end else begin
            chk("cmp_tvalid0", 128'(o_tv0[d][c]), 128'(0));
            chk("cmp_tvalid1", 128'(o_tv1[d][c]), 128'(0));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] mk_d0(input logic [3:0] pid,
                                         input logic [31:0] tag);
    return {8'h5A, pid, 20'h12345, tag, tag, tag};
  endfunction

  task automatic push(input int d, input logic [3:0] pid,
                      input logic l1v, input logic [31:0] tag);
    in_v0[d] = 1'b1;
    in_v1[d] = l1v;
    in_d0[d] = mk_d0(pid, tag);
    in_d1[d] = {4{tag ^ 32'h5555AAAA}};
    tick(1);
    in_v0[d] = 1'b0;
    in_v1[d] = 1'b0;
  endtask

  initial begin : main
    logic [31:0] t;
    int fall_idx;
    int held;
    for (int d = 0; d < 2; d++) begin
      in_v0[d] = 1'b0;
      in_v1[d] = 1'b0;
      in_d0[d] = '0;
      in_d1[d] = '0;
      eready[d] = 9'h1FF;
    end
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_tready", 128'(o_rdy[0]), 128'(0));
    chk("rst_tvalid", 128'(o_tv0[0]), 128'(0));
    rst = 1'b0;
    tick(1);
    chk("rst_tready_up", 128'(o_rdy[0]), 128'(1));
    chk("rst_badcnt", 128'(bad0), 128'(0));

    // Single entry to port 2, visible exactly one cycle.
    push(0, 4'd2, 1'b0, 32'h101);
    chk("t1_early", 128'(o_tv0[0][2]), 128'(0));
    tick(1);
    chk("t1_tvalid", 128'(o_tv0[0][2]), 128'(1));
    chk("t1_tdata", o_td0[0][2*128 +: 128],
        128'h5A012345_00000101_00000101_00000101);
    tick(1);
    chk("t1_gone", 128'(o_tv0[0][2]), 128'(0));

    // Port 8, lane 1 valid then invalid.
    push(0, 4'd8, 1'b1, 32'h201);
    push(0, 4'd8, 1'b0, 32'h202);
    chk("t2_l1v_a", 128'(o_tv1[0][8]), 128'(1));
    chk("t2_l1d_a", o_td1[0][8*128 +: 128],
        128'h5555A8AB_5555A8AB_5555A8AB_5555A8AB);
    tick(1);
    chk("t2_l0v_b", 128'(o_tv0[0][8]), 128'(1));
    chk("t2_l1v_b", 128'(o_tv1[0][8]), 128'(0));
    tick(1);

    // Stalled ch0: 20 writes into 16 entries.
    eready[0][0] = 1'b0;
    for (int i = 0; i < 20; i++) push(0, 4'd0, 1'b0, 32'h300 + 32'(i));
    tick(2);
    chk("t3_drop", 128'(drop0[3:0]), 128'(4));
    eready[0][0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t = 32'h300 + 32'(i);
      chk("t3_order_v", 128'(o_tv0[0][0]), 128'(1));
      chk("t3_order_d", o_td0[0][127:0],
          {8'h5A, 4'h0, 20'h12345, t, t, t});
      tick(1);
    end
    chk("t3_empty", 128'(o_tv0[0][0]), 128'(0));

    // Port id outside the channel range.
    push(0, 4'd12, 1'b1, 32'h400);
    tick(1);
    chk("t4_novalid", 128'(o_tv0[0]), 128'(0));
    chk("t4_bad", 128'(bad0), 128'(1));
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    chk("t4_bad_clr", 128'(bad0), 128'(0));
    chk("t4_drop_clr", 128'(drop0[3:0]), 128'(0));

    // Backpressure mode, ch3 stalled, continuous input.
    eready[1][3] = 1'b0;
    fall_idx = -1;
    in_v0[1] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_d0[1] = mk_d0(4'd3, 32'h500 + 32'(i));
      in_d1[1] = '0;
      tick(1);
      if (!o_rdy[1] && fall_idx < 0) fall_idx = i;
    end
    in_v0[1] = 1'b0;
    tick(3);
    chk("t5_fall", 128'(fall_idx), 128'(15));
    chk("t5_tready", 128'(o_rdy[1]), 128'(0));
    chk("t5_drop", 128'(drop1[3*16 +: 16]), 128'(0));
    eready[1][3] = 1'b1;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_tv0[1][3]) held++;
      tick(1);
    end
    chk("t5_held", 128'(held), 128'(16));

    // Saturation at 15, then reset with entries stored.
    eready[0][0] = 1'b0;
    for (int i = 0; i < 36; i++) push(0, 4'd0, 1'b0, 32'h600 + 32'(i));
    for (int i = 0; i < 17; i++) push(0, 4'd15, 1'b0, 32'h700);
    eready[0][1] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 4'd1, 1'b1, 32'h800 + 32'(i));
    tick(2);
    chk("t6_sat_drop", 128'(drop0[3:0]), 128'(15));
    chk("t6_sat_bad", 128'(bad0), 128'(15));
    chk("t6_pre_v", 128'(o_tv0[0][1]), 128'(1));
    rst = 1'b1;
    tick(1);
    chk("t6_rst_tready", 128'(o_rdy[0]), 128'(0));
    rst = 1'b0;
    chk("t6_rst_v0", 128'(o_tv0[0]), 128'(0));
    chk("t6_rst_v1", 128'(o_tv1[0]), 128'(0));
    chk("t6_rst_drop", 128'(drop0), 128'(0));
    chk("t6_rst_bad", 128'(bad0), 128'(0));
    eready[0] = 9'h1FF;
    tick(1);
    chk("t6_tready_up", 128'(o_rdy[0]), 128'(1));
    chk("t6_still_empty", 128'(o_tv0[0][1]), 128'(0));
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
